instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 WriteReg  output  1  register-write enable decoded from the current instruction.
REQ-005 SEtoReg  output  1  select-immediate-to-register control decoded from the current instruction.
REQ-006 instruction  output  8  instruction word currently addressed by the PC.

Function
REQ-007 The block SHALL hold an 8-bit PC register, updated only on the rising clk edge.
REQ-008 The block SHALL hold a 256 x 8 instruction memory, read combinationally at address PC; instruction = mem[PC], with zero cycles of latency.
REQ-009 Instruction fields SHALL be: opcode = instruction[7:6], imm = instruction[5:0].
REQ-010 Decode is combinational from the opcode. The outputs SHALL be:
  - 00: WriteReg=1, SEtoReg=0, PCSrc=0.
  - 01: WriteReg=1, SEtoReg=1, PCSrc=0.
  - 10: all 0 (no-op).
  - 11 (jump): PCSrc=1, WriteReg=0, SEtoReg=0.
REQ-011 The sequential address SHALL be seq = PC + 1, modulo 256 (0xFF wraps to 0x00).
REQ-012 The jump target SHALL be built from the 8-bit adder: target = {seq[7:6], 6'b0} + {2'b00, imm}, which equals {seq[7:6], imm}.
REQ-013 The next PC SHALL be target when PCSrc=1, else seq.
REQ-014 PC SHALL advance every non-reset cycle; there is no stall input.
REQ-015 A jump at 0xFF SHALL use seq = 0x00, giving target = {2'b00, imm}.
REQ-016 The memory SHALL be read-only; no write port.

Reset
REQ-017 On a rising edge with reset=1, PC SHALL become 0x00, so instruction = mem[0] after that edge.
REQ-018 On the same edge, memory SHALL be loaded with the following program; all other addresses = 0x00:
  - [0] = 0x01
  - [1] = 0x4A
  - [2] = 0x85
  - [3] = 0xC6
  - [4] = 0x00
  - [5] = 0x00
  - [6] = 0xC0
REQ-019 Reset SHALL take priority over the next-PC selection, including a jump in flight.
REQ-020 Reset asserted mid-operation SHALL return PC to 0x00 at the next edge; memory SHALL be reloaded identically.
REQ-021 Outputs before the first reset edge are undefined; verification SHALL NOT check them.
REQ-022 After reset deasserts, the program sequence SHALL be: PC = 0, 1, 2, 3, 6, 0, 1, 2, 3, 6, ... repeating.

Verification
REQ-023 Reset for one edge, then check the first two cycles:
  - instruction=0x01, WriteReg=1, SEtoReg=0.
  - next edge: instruction=0x4A, WriteReg=1, SEtoReg=1.
REQ-024 Third and fourth cycles after reset:
  - instruction=0x85, WriteReg=0, SEtoReg=0.
  - then instruction=0xC6, both controls 0.
  - next edge: PC=6, instruction=0xC0.
REQ-025 From PC=6 (0xC0), one edge -> PC=0, instruction=0x01; run 20 cycles and check the period-5 loop of REQ-022.
REQ-026 Assert reset while PC=3 (jump pending) -> after that edge PC=0x00, instruction=0x01; no jump to 6.
REQ-027 Arithmetic checks:
  - Force PC=0xFF with a non-jump word -> next PC=0x00.
  - Jump word 0xE5 at PC=0x40 -> next PC=0x65.
  - Jump at 0xFF with imm=0x25 -> next PC=0x25.
REQ-028 Decode sweep: all 4 opcode values drive WriteReg/SEtoReg exactly per REQ-010; PCSrc checked via the next-PC value.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, boot-loaded read-only instruction
// memory, combinational decode of the addressed word and next-PC selection.
module instruction_fetch (
  input  logic       clk,
  input  logic       reset,
  output logic       WriteReg,
  output logic       SEtoReg,
  output logic [7:0] instruction
);

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 256;

  // Program image written into the memory on every reset edge
  function automatic logic [DEPTH-1:0][DW-1:0] boot_image();
    logic [DEPTH-1:0][DW-1:0] img;
    img    = '0;
    img[0] = 8'h01;
    img[1] = 8'h4A;
    img[2] = 8'h85;
    img[3] = 8'hC6;
    img[4] = 8'h00;
    img[5] = 8'h00;
    img[6] = 8'hC0;
    return img;
  endfunction

  logic [DEPTH-1:0][DW-1:0] mem_q;
  logic [AW-1:0]            pc_q;
  logic [AW-1:0]            pc_d;
  logic [AW-1:0]            seq_addr;
  logic [AW-1:0]            jump_target;
  logic [1:0]               opcode;
  logic [5:0]               imm;
  logic                     pc_src;

  // Memory has no write port; its only update is the reload on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= boot_image();
    end
  end

  // PC register; reset wins over any pending jump
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Zero-latency fetch and field split
  always_comb begin
    instruction = mem_q[pc_q];
    opcode      = instruction[7:6];
    imm         = instruction[5:0];
  end

  // Opcode decode into register-file controls and the jump select
  always_comb begin
    WriteReg = 1'b0;
    SEtoReg  = 1'b0;
    pc_src   = 1'b0;
    case (opcode)
      2'b00: WriteReg = 1'b1;
      2'b01: begin
        WriteReg = 1'b1;
        SEtoReg  = 1'b1;
      end
      2'b11: pc_src = 1'b1;
      default: ;
    endcase
  end

  // Next PC: sequential address wraps at 0xFF; jump keeps the top two bits
  // of the sequential address and replaces the low six with the immediate
  always_comb begin
    seq_addr    = pc_q + AW'(1);
    jump_target = (seq_addr & 8'hC0) + {2'b00, imm};
    pc_d        = pc_src ? jump_target : seq_addr;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus pushes expected state,
// a negedge monitor pops and compares against the DUT.
module tb_instruction_fetch;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] instr;
    logic       wr;
    logic       se;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       WriteReg;
  logic       SEtoReg;
  logic [7:0] instruction;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .WriteReg    (WriteReg),
    .SEtoReg     (SEtoReg),
    .instruction (instruction)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  // Reference model state: whole-word memory and PC as plain integers
  int                 m_mem[256];
  int                 m_pc;
  bit                 m_forced = 1'b0;
  logic [255:0][7:0]  img;

  // Directed expectations for the boot program loop 0,1,2,3,6
  int tab_pc[5]    = '{0, 1, 2, 3, 6};
  int tab_instr[5] = '{'h01, 'h4A, 'h85, 'hC6, 'hC0};
  int tab_wr[5]    = '{1, 1, 0, 0, 0};
  int tab_se[5]    = '{0, 1, 0, 0, 0};

  function automatic int prog_word(input int a);
    case (a)
      0: return 'h01;
      1: return 'h4A;
      2: return 'h85;
      3: return 'hC6;
      6: return 'hC0;
      default: return 0;
    endcase
  endfunction

  // One clock edge of the behavioural model
  task automatic model_edge(input bit rst);
    int w;
    int nxt;
    if (rst) begin
      m_pc = 0;
      if (!m_forced) begin
        for (int i = 0; i < 256; i++) m_mem[i] = prog_word(i);
      end
    end else begin
      w   = m_mem[m_pc];
      nxt = (m_pc + 1) % 256;
      if (w / 64 == 3) nxt = (nxt / 64) * 64 + (w % 64);
      m_pc = nxt;
    end
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    int   w;
    w       = m_mem[m_pc];
    e.pc    = 8'(m_pc);
    e.instr = 8'(w);
    e.wr    = (w / 64) < 2;
    e.se    = (w / 64) == 1;
    return e;
  endfunction

  task automatic step(input bit rst, input bit push);
    reset = rst;
    @(posedge clk);
    #1;
    model_edge(rst);
    if (push) sb_q.push_back(model_expect());
  endtask

  task automatic step_tab(input bit rst, input int idx);
    exp_t e;
    reset = rst;
    @(posedge clk);
    #1;
    model_edge(rst);
    e.pc    = 8'(tab_pc[idx]);
    e.instr = 8'(tab_instr[idx]);
    e.wr    = tab_wr[idx] != 0;
    e.se    = tab_se[idx] != 0;
    sb_q.push_back(e);
  endtask

  // Override memory contents with img, then start from PC 0
  task automatic apply_image();
    step(1'b1, 1'b0);
    for (int i = 0; i < 256; i++) m_mem[i] = int'(img[i]);
    m_forced = 1'b1;
    force dut.mem_q = img;
    step(1'b1, 1'b1);
  endtask

  // Drop the override; a reset edge restores the boot program
  task automatic drop_image();
    step(1'b1, 1'b0);
    release dut.mem_q;
    m_forced = 1'b0;
    step(1'b1, 1'b1);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per cycle, compared away from the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc",          int'(dut.pc_q),   int'(e.pc));
        chk("instruction", int'(instruction), int'(e.instr));
        chk("WriteReg",    int'(WriteReg),    int'(e.wr));
        chk("SEtoReg",     int'(SEtoReg),     int'(e.se));
      end
    end
  end

  initial begin
    reset = 1'b1;

    // Boot program: reset edge then the 0,1,2,3,6 loop
    step_tab(1'b1, 0);
    for (int k = 1; k < 29; k++) step_tab(1'b0, k % 5);
    // PC is 3 here with a jump pending; reset must win
    step_tab(1'b1, 0);
    step_tab(1'b0, 1);
    step_tab(1'b0, 2);

    // Random resets over the boot program
    for (int k = 0; k < 60; k++) step(($urandom_range(0, 15) == 0), 1'b1);

    // Jump at 0x40 (0xE5 -> 0x65) and jump at 0xFF (imm 0x25 -> 0x25)
    img        = '0;
    img[8'h40] = 8'hE5;
    img[8'hFF] = 8'hE5;
    apply_image();
    for (int k = 0; k < 300; k++) step(1'b0, 1'b1);
    drop_image();

    // Non-jump word at 0xFF wraps to 0x00
    img = '0;
    apply_image();
    for (int k = 0; k < 270; k++) step(1'b0, 1'b1);
    drop_image();

    // Random memory images sweep every opcode with random resets
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
      apply_image();
      for (int k = 0; k < 120; k++) step(($urandom_range(0, 15) == 0), 1'b1);
      drop_image();
    end

    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
